// File: rtl/top2_scan_ctrl.sv
// Scan controller: reads a window of RAM words, tracks the two largest values
// and hands the result out through a valid/ready handshake.
module top2_scan_ctrl #(
    parameter int DATAW = 4,
    parameter int SIZE  = 32,
    parameter int ADDRW = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   length,
    output logic             busy,
    output logic             ren,
    output logic [ADDRW-1:0] raddr,
    input  logic [DATAW-1:0] rdata,
    output logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DATAW-1:0] highest,
    output logic [DATAW-1:0] second_highest
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [ADDRW:0]   SIZE_L   = (ADDRW+1)'(SIZE);
    localparam logic [ADDRW-1:0] LAST_ADR = ADDRW'(SIZE - 1);

    state_t           state_q;
    logic [ADDRW:0]   len_q;
    logic [ADDRW:0]   cnt_q;
    logic [ADDRW-1:0] raddr_q;
    logic             ren_q;
    logic             rvalid_q;
    logic             busy_q;
    logic             done_q;
    logic             res_valid_q;
    logic [DATAW-1:0] highest_q;
    logic [DATAW-1:0] second_q;
    logic [DATAW-1:0] highest_d;
    logic [DATAW-1:0] second_d;
    logic [ADDRW:0]   len_clamped_s;
    logic [ADDRW-1:0] next_addr_s;

    function automatic logic [ADDRW:0] clamp_len(input logic [ADDRW:0] l);
        if (l > SIZE_L) begin
            return SIZE_L;
        end else begin
            return l;
        end
    endfunction

    // Window length and wrapping address increment
    always_comb begin
        len_clamped_s = clamp_len(length);
        if (raddr_q == LAST_ADR) begin
            next_addr_s = {ADDRW{1'b0}};
        end else begin
            next_addr_s = raddr_q + {{(ADDRW-1){1'b0}}, 1'b1};
        end
    end

    // Top-two update for the word returned this cycle; ties fall to second
    always_comb begin
        highest_d = highest_q;
        second_d  = second_q;
        if (rvalid_q) begin
            if (rdata > highest_q) begin
                second_d  = highest_q;
                highest_d = rdata;
            end else if (rdata > second_q) begin
                second_d = rdata;
            end else begin
                second_d = second_q;
            end
        end else begin
            highest_d = highest_q;
        end
    end

    // Scan FSM with registered outputs; cnt_q counts addresses already issued
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= {(ADDRW+1){1'b0}};
            cnt_q       <= {(ADDRW+1){1'b0}};
            raddr_q     <= {ADDRW{1'b0}};
            ren_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            highest_q   <= {DATAW{1'b0}};
            second_q    <= {DATAW{1'b0}};
        end else begin
            rvalid_q  <= ren_q;
            highest_q <= highest_d;
            second_q  <= second_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q     <= len_clamped_s;
                        highest_q <= {DATAW{1'b0}};
                        second_q  <= {DATAW{1'b0}};
                        busy_q    <= 1'b1;
                        if (len_clamped_s == {(ADDRW+1){1'b0}}) begin
                            state_q     <= RESULT;
                            res_valid_q <= 1'b1;
                            done_q      <= 1'b1;
                            cnt_q       <= {(ADDRW+1){1'b0}};
                        end else begin
                            state_q <= READ;
                            ren_q   <= 1'b1;
                            raddr_q <= base_addr;
                            cnt_q   <= {{ADDRW{1'b0}}, 1'b1};
                        end
                    end
                end
                READ: begin
                    if (cnt_q == len_q) begin
                        state_q <= DRAIN;
                        ren_q   <= 1'b0;
                    end else begin
                        raddr_q <= next_addr_s;
                        cnt_q   <= cnt_q + {{ADDRW{1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    state_q     <= RESULT;
                    res_valid_q <= 1'b1;
                    done_q      <= 1'b1;
                end
                RESULT: begin
                    done_q <= 1'b0;
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ren_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign ren            = ren_q;
    assign raddr          = raddr_q;
    assign done           = done_q;
    assign res_valid      = res_valid_q;
    assign highest        = highest_q;
    assign second_highest = second_q;

endmodule

// File: tb/tb_top2_scan_ctrl.sv
// Directed bench for top2_scan_ctrl with a 1-cycle-latency RAM model.
module tb_top2_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base_addr = 5'd0;
    logic [5:0] length = 6'd0;
    logic       busy;
    logic       ren;
    logic [4:0] raddr;
    logic [3:0] rdata = 4'd0;
    logic       done;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [3:0] highest;
    logic [3:0] second_highest;

    logic [3:0] mem [32];
    int tests = 0;
    int fails = 0;

    top2_scan_ctrl #(.DATAW(4), .SIZE(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .ren(ren), .raddr(raddr),
        .rdata(rdata), .done(done), .res_valid(res_valid),
        .res_ready(res_ready), .highest(highest),
        .second_highest(second_highest)
    );

    always #5 clk = ~clk;

    // RAM model: data for an address appears the cycle after the read
    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    task automatic chk_val(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_scan(input string tag, input int b, input int len,
                            input int ehi, input int esec, input int hold);
        int l_exp;
        int resc;
        l_exp = (len > 32) ? 32 : len;
        resc  = (l_exp == 0) ? 1 : l_exp + 2;
        @(negedge clk);
        res_ready = (hold == 0);
        start     = 1'b1;
        base_addr = b[4:0];
        length    = len[5:0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= resc; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= l_exp)
                chk_val({tag, " ren/raddr"}, {ren, raddr}, 32 + ((b + c - 1) % 32));
            else
                chk_val({tag, " ren"}, ren, 0);
            chk_val({tag, " busy"}, busy, 1);
            if (c < resc) begin
                chk_val({tag, " early valid"}, res_valid, 0);
                chk_val({tag, " early done"}, done, 0);
            end
        end
        chk_val({tag, " res_valid"}, res_valid, 1);
        chk_val({tag, " done"}, done, 1);
        chk_val({tag, " highest"}, highest, ehi);
        chk_val({tag, " second"}, second_highest, esec);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            start = (h == 2);
            chk_val({tag, " held valid"}, res_valid, 1);
            chk_val({tag, " held done"}, done, 0);
            chk_val({tag, " held highest"}, highest, ehi);
            chk_val({tag, " held second"}, second_highest, esec);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk_val({tag, " idle busy"}, busy, 0);
        chk_val({tag, " idle valid"}, res_valid, 0);
        chk_val({tag, " kept highest"}, highest, ehi);
        chk_val({tag, " kept second"}, second_highest, esec);
        @(negedge clk);
        chk_val({tag, " still idle"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst busy", busy, 0);
        chk_val("rst ren", ren, 0);
        chk_val("rst raddr", raddr, 0);
        chk_val("rst done", done, 0);
        chk_val("rst valid", res_valid, 0);
        chk_val("rst highest", highest, 0);
        chk_val("rst second", second_highest, 0);
        reset = 1'b1;

        mem[0] = 4'd3; mem[1] = 4'd9; mem[2] = 4'd1; mem[3] = 4'd9;
        mem[4] = 4'd4; mem[5] = 4'd0; mem[6] = 4'd2; mem[7] = 4'd5;
        run_scan("dup9", 0, 8, 9, 9, 0);

        mem[28] = 4'd2; mem[29] = 4'd6; mem[30] = 4'd5; mem[31] = 4'd1;
        mem[0] = 4'd7; mem[1] = 4'd3;
        run_scan("wrap", 28, 6, 7, 6, 0);

        run_scan("len0", 5, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) mem[i] = 4'd1;
        mem[0] = 4'd11; mem[31] = 4'd12;
        run_scan("clamp40", 0, 40, 12, 11, 0);

        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd4;
        run_scan("asc bp", 0, 4, 4, 3, 5);

        mem[0] = 4'd4; mem[1] = 4'd3; mem[2] = 4'd2; mem[3] = 4'd1;
        run_scan("desc", 0, 4, 4, 3, 0);

        mem[0] = 4'd5; mem[1] = 4'd2; mem[2] = 4'd8; mem[3] = 4'd1;
        mem[4] = 4'd7; mem[5] = 4'd0; mem[6] = 4'd3; mem[7] = 4'd6;
        @(negedge clk);
        start = 1'b1; base_addr = 5'd0; length = 6'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_val("midrst busy", busy, 0);
        chk_val("midrst ren", ren, 0);
        chk_val("midrst raddr", raddr, 0);
        chk_val("midrst done", done, 0);
        chk_val("midrst valid", res_valid, 0);
        chk_val("midrst highest", highest, 0);
        chk_val("midrst second", second_highest, 0);
        reset = 1'b1;
        run_scan("after rst", 0, 8, 8, 7, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top2_scan_ctrl.md
Name: top2_scan_ctrl

Overview:
Sequencing controller for the highest/second-highest search over the sample RAM. On a start command it scans a programmable window of RAM addresses, compensates for the RAM's 1-cycle read latency, and updates the top-two tracker. It then presents the result through a valid/ready handshake. It sits between the test/control logic and the `ram` instance, and owns the RAM read port during a scan.

Parameters:
DATAW, 4, width of each RAM word and of both result outputs
SIZE, 32, RAM depth in words
ADDRW, $clog2(SIZE), RAM address width

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising edge of clk)
start  input  1  scan request; sampled only in IDLE
base_addr  input  ADDRW  first address to scan; captured when start is accepted
length  input  ADDRW+1  number of words to scan, 0..SIZE; captured when start is accepted
busy  output  1  high in every state except IDLE
ren  output  1  RAM read enable
raddr  output  ADDRW  RAM read address
rdata  input  DATAW  RAM read data; valid one cycle after ren/raddr
done  output  1  one-cycle pulse on entry to RESULT
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
highest  output  DATAW  largest value scanned
second_highest  output  DATAW  second largest value scanned (duplicates count)

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; busy, ren, done and res_valid =0; raddr, highest and second_highest =0. This applies mid-scan and mid-RESULT too. There is no partial result and no pending handshake survives.
- States: IDLE, READ, DRAIN, RESULT.
- IDLE, start=1:
  - Capture base_addr and len.
  - len=min(length,SIZE); any length>SIZE is clamped to SIZE.
  - Clear highest and second_highest to 0 and the issue counter to 0.
  - len=0 goes straight to RESULT; otherwise go to READ.
- READ:
  - ren=1 and raddr=(base+k) mod SIZE, where k=0..len-1, one address per cycle with no gaps.
  - Address wrap-around is modulo SIZE; for SIZE a power of two this is plain ADDRW-bit overflow.
  - After issuing the address with k=len-1, go to DRAIN.
- DRAIN: ren=0 and raddr holds its last value. Exactly one cycle, during which the final word is consumed. Then go to RESULT.
- Data capture:
  - rvalid is a 1-cycle delayed copy of ren.
  - In any cycle with rvalid=1, rdata is compared and the registers update at the clock edge.
  - Update rule:
    - rdata>highest: second_highest<=highest, highest<=rdata.
    - Else, if rdata>second_highest: second_highest<=rdata.
    - Else: no change.
  - Comparisons are unsigned, DATAW bits. Ties with highest land in second_highest, so {7,7} gives 7/7.
  - Single-word scan: highest=word, second_highest=0.
- RESULT:
  - res_valid=1 and busy=1.
  - highest/second_highest are stable while res_valid=1.
  - done=1 only in the first cycle of RESULT.
  - Stay until res_valid&&res_ready, then go to IDLE.
- After the handshake, highest and second_highest hold their values until the next accepted start.
- Latency:
  - Start accepted at edge 0 with len=L>0: first address issued in cycle 1, last in cycle L, DRAIN in cycle L+1, res_valid/done in cycle L+2.
  - len=0: res_valid/done in cycle 1.
- start while busy (including the RESULT cycle in which the handshake completes) is ignored, not queued.
- res_ready while res_valid=0 has no effect.
- Throughput: a new scan can be accepted no earlier than the cycle after returning to IDLE.

Test Plan:
- RAM[0..7]={3,9,1,9,4,0,2,5}, base=0, length=8, res_ready=1 -> ren high cycles 1-8, raddr 0..7; done and res_valid in cycle 10; highest=9, second_highest=9.
- RAM[28..31]={2,6,5,1}, RAM[0..1]={7,3}, base=28, length=6 -> raddr sequence 28,29,30,31,0,1; highest=7, second_highest=6; res_valid at cycle 8.
- length=0 -> res_valid and done in cycle 1, highest=0, second_highest=0, ren never asserted. Then length=40 with base=0 -> exactly 32 reads, addresses 0..31.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid and result held constant, done high only in the first cycle. Pulse start during this window -> ignored. Raise res_ready -> IDLE the next cycle.
- Ascending RAM[0..3]={1,2,3,4} -> highest=4, second_highest=3. Descending {4,3,2,1} -> highest=4, second_highest=3, which checks the else-if branch.
- Assert reset=0 in cycle 3 of an 8-word scan -> at the next edge busy=0, ren=0, all outputs 0, state IDLE. A fresh start afterwards gives the correct full result.
